// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC = 32'h0000_0000;
    localparam word_t PC_STEP  = 32'd4;
    localparam word_t INST_NOP = 32'h0000_0000;

    // Clear the two low bits so every PC is word aligned.
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode handshake: one registered instruction behind valid/ready.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic  id_valid;
    logic  id_ready;
    word_t id_inst;
    word_t id_pc;
    word_t id_pc_next;

    // Fetch side drives the instruction, decode side drives ready.
    modport master (
        output id_valid,
        output id_inst,
        output id_pc,
        output id_pc_next,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_inst,
        input  id_pc,
        input  id_pc_next,
        output id_ready
    );

endinterface

// File: rtl/pc_next.sv
// Next-PC selection: redirect target (aligned), sequential step, or hold.
module pc_next
    import cpu_pkg::*;
(
    input  word_t pc_q,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    input  logic  capture,
    output word_t pc_d
);

    // Redirect wins over the sequential step; a stalled stage keeps its PC.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
        end else if (capture) begin
            pc_d = pc_q + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, registers ROM output for decode, counts handoffs.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    output word_t         rom_addr,
    input  word_t         rom_inst,
    input  logic          redirect_valid,
    input  word_t         redirect_pc,
    fetch_stage_if.master id,
    output word_t         fetch_count
);

    word_t pc_q;
    word_t pc_d;
    logic  id_valid_q;
    word_t id_inst_q;
    word_t id_pc_q;
    word_t id_pc_next_q;
    word_t fetch_count_q;
    logic  capture;
    logic  handoff;

    assign capture = !id_valid_q || id.id_ready;
    assign handoff = id_valid_q && id.id_ready;

    pc_next u_pc_next (
        .pc_q           (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .capture        (capture),
        .pc_d           (pc_d)
    );

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Output register: a redirect flushes it, otherwise it refills whenever it can.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q   <= 1'b0;
            id_inst_q    <= INST_NOP;
            id_pc_q      <= '0;
            id_pc_next_q <= '0;
        end else if (redirect_valid) begin
            id_valid_q <= 1'b0;
        end else if (capture) begin
            id_valid_q   <= 1'b1;
            id_inst_q    <= rom_inst;
            id_pc_q      <= pc_q;
            id_pc_next_q <= pc_q + PC_STEP;
        end
    end

    // Count completed handoffs, including one that coincides with a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else if (handoff) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign rom_addr      = pc_q;
    assign id.id_valid   = id_valid_q;
    assign id.id_inst    = id_inst_q;
    assign id.id_pc      = id_pc_q;
    assign id.id_pc_next = id_pc_next_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small behavioural ROM.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic  clk;
    logic  rst_n;
    word_t rom_addr;
    word_t rom_inst;
    logic  redirect_valid;
    word_t redirect_pc;
    word_t fetch_count;

    int unsigned n_checks;
    int unsigned n_passed;

    word_t rom [64];

    fetch_stage_if id_bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id             (id_bus.master),
        .fetch_count    (fetch_count)
    );

    // ROM decodes only word index addr[7:2].
    assign rom_inst = rom[rom_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle on the opposite edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        rom[0]  = 32'h0000_0000;
        rom[1]  = 32'h1400_1863;
        rom[2]  = 32'h0050_0093;
        rom[3]  = 32'h00a0_0113;
        rom[4]  = 32'h0020_81b3;
        rom[6]  = 32'h0010_0822;
        rom[63] = 32'hdead_beef;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_bus.id_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_valid",  word_t'(id_bus.id_valid), 32'd0);
        check("rst_inst",   id_bus.id_inst, 32'h0);
        check("rst_pc",     id_bus.id_pc, 32'h0);
        check("rst_pcnext", id_bus.id_pc_next, 32'h0);
        check("rst_count",  fetch_count, 32'd0);
        check("rst_addr",   rom_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch.
        step();
        check("c2_valid", word_t'(id_bus.id_valid), 32'd1);
        check("c2_pc",    id_bus.id_pc, 32'h0);
        check("c2_inst",  id_bus.id_inst, 32'h0);
        check("c2_addr",  rom_addr, 32'h4);
        check("c2_count", fetch_count, 32'd0);
        step();
        check("c3_pc",     id_bus.id_pc, 32'h4);
        check("c3_inst",   id_bus.id_inst, 32'h1400_1863);
        check("c3_pcnext", id_bus.id_pc_next, 32'h8);
        check("c3_count",  fetch_count, 32'd1);
        step();
        check("c4_pc",    id_bus.id_pc, 32'h8);
        check("c4_count", fetch_count, 32'd2);
        check("c4_addr",  rom_addr, 32'hC);

        // Stall for three edges.
        id_bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", word_t'(id_bus.id_valid), 32'd1);
            check("stall_pc",    id_bus.id_pc, 32'h8);
            check("stall_inst",  id_bus.id_inst, 32'h0050_0093);
            check("stall_addr",  rom_addr, 32'hC);
            check("stall_count", fetch_count, 32'd2);
        end
        id_bus.id_ready = 1'b1;
        step();
        check("resume_pc",    id_bus.id_pc, 32'hC);
        check("resume_inst",  id_bus.id_inst, 32'h00a0_0113);
        check("resume_count", fetch_count, 32'd3);

        // Redirect while stalled discards the held instruction.
        id_bus.id_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h18;
        step();
        check("rd18_valid", word_t'(id_bus.id_valid), 32'd0);
        check("rd18_addr",  rom_addr, 32'h18);
        check("rd18_count", fetch_count, 32'd3);
        redirect_valid  = 1'b0;
        id_bus.id_ready = 1'b1;
        step();
        check("rd18_pc",     id_bus.id_pc, 32'h18);
        check("rd18_inst",   id_bus.id_inst, 32'h0010_0822);
        check("rd18_pcnext", id_bus.id_pc_next, 32'h1C);
        check("rd18_valid2", word_t'(id_bus.id_valid), 32'd1);

        // Misaligned redirect with a concurrent handoff.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        step();
        check("rd13_addr",  rom_addr, 32'h10);
        check("rd13_valid", word_t'(id_bus.id_valid), 32'd0);
        check("rd13_count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        step();
        check("rd13_pc",   id_bus.id_pc, 32'h10);
        check("rd13_inst", id_bus.id_inst, 32'h0020_81b3);

        // Wrap at the top of the address space; high PCs alias into the ROM.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        check("wrap_count0", fetch_count, 32'd5);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc",     id_bus.id_pc, 32'hFFFF_FFFC);
        check("wrap_pcnext", id_bus.id_pc_next, 32'h0);
        check("wrap_addr",   rom_addr, 32'h0);
        check("wrap_inst",   id_bus.id_inst, 32'hdead_beef);
        step();
        check("wrap_pc2",   id_bus.id_pc, 32'h0);
        check("wrap_count", fetch_count, 32'd6);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", word_t'(id_bus.id_valid), 32'd0);
        check("arst_addr",  rom_addr, RESET_PC);
        check("arst_count", fetch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rr_pc",    id_bus.id_pc, 32'h0);
        check("rr_valid", word_t'(id_bus.id_valid), 32'd1);
        step();
        check("rr_pc2",   id_bus.id_pc, 32'h4);
        check("rr_inst",  id_bus.id_inst, 32'h1400_1863);
        check("rr_count", fetch_count, 32'd1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the CPU pipeline, directly upstream of the instruction ROM and feeding decode. It owns the program counter and drives the combinational ROM address. It registers each returned instruction word with its PC into a one-entry output register behind a valid/ready handshake. It also accepts redirects (branch/jump) from later stages and counts instructions handed to decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- PC_STEP, 4, byte increment per sequential fetch
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rom_addr  out  32  byte address to instruction ROM; equals pc_q
- rom_inst  in  32  instruction word from ROM, combinational from rom_addr
- redirect_valid  in  1  load redirect_pc this cycle; flushes output register
- redirect_pc  in  32  redirect target byte address
- id_valid  out  1  output register holds an instruction for decode
- id_ready  in  1  decode accepts this cycle
- id_inst  out  32  registered instruction word
- id_pc  out  32  byte address id_inst was fetched from
- id_pc_next  out  32  id_pc + PC_STEP, mod 2^32
- fetch_count  out  32  instructions handed to decode (id_valid && id_ready), wraps

## Operation
- Reset values: pc_q=RESET_PC, id_valid=0, id_inst=0, id_pc=0, id_pc_next=0, fetch_count=0.
- capture = !id_valid || id_ready.
- Per edge, in priority order:
  - If redirect_valid: pc_q <= {redirect_pc[31:2],2'b00}. id_valid <= 0. id_inst/id_pc are left unchanged and ignored.
  - Else if capture: id_inst <= rom_inst. id_pc <= pc_q. id_pc_next <= pc_q+PC_STEP. id_valid <= 1. pc_q <= pc_q+PC_STEP.
  - Else (stalled): all state holds. rom_addr is stable.
- fetch_count increments on every edge with id_valid && id_ready, including a redirect edge, because that handoff has completed.
- Arithmetic: 32-bit unsigned, wraps. PC 32'hFFFF_FFFC steps to 32'h0.
- Misaligned redirect: bits [1:0] are forced to 0. No error is raised.
- ROM decodes only addr[7:2]. PCs at or above 0x100 alias into the 64-word ROM. This is intended; the fetch stage does not flag it.
- Redirect while stalled: the held instruction is discarded, and decode sees id_valid=0 next cycle.

## Timing
- Fetch latency: 1 cycle from pc_q presented to id_inst valid.
- After rst_n deasserts: first edge captures rom[RESET_PC]. id_valid=1 after that edge.
- Sustained throughput: 1 instruction/cycle while id_ready=1 and no redirect.
- Redirect penalty: 1 bubble. Edge N loads the target. Edge N+1 captures rom[target], so id_valid is 0 for exactly one cycle.
- Handshake: id_inst, id_pc and id_pc_next are stable while id_valid && !id_ready. id_valid never drops without a handshake except on redirect or reset.
- rst_n assertion mid-stream clears all state immediately, with no clock needed. The in-flight instruction is lost.

## Structure
- Shared package cpu_pkg holds:
  - RESET_PC default
  - PC_STEP
  - INST_NOP = 32'h0000_0000
  - word width 32
- One sub-module, pc_next: combinational next-PC mux (redirect / increment / hold) plus alignment masking. The top holds the registers, handshake and counter.
- The ROM is instantiated beside this block in the top-level, not inside it.

## Test plan
- Reset then id_ready=1 with the program ROM: cycle 1 rom_addr=0x0, id_valid=0. Cycle 2 id_valid=1, id_pc=0x0, id_inst=0x00000000, rom_addr=0x4. Cycle 3 id_pc=0x4, id_inst=0x14001863, id_pc_next=0x8. fetch_count increments by 1 per cycle from cycle 2.
- Hold id_ready=0 for 3 cycles with id_pc=0x8: id_inst, id_pc, rom_addr=0xC and fetch_count are all stable. id_ready=1 resumes at 0xC with no skipped or duplicated PC.
- redirect_valid with redirect_pc=0x18 while stalled: next cycle id_valid=0, rom_addr=0x18. Following cycle id_pc=0x18, id_inst=0x00100822.
- redirect_pc=0x13: rom_addr=0x10, then id_pc=0x10.
- redirect_pc=0xFFFFFFFC with id_ready=1: id_pc=0xFFFFFFFC, id_pc_next=0x0, rom_addr=0x0 the next cycle.
- Assert rst_n low mid-stream between edges: id_valid=0, rom_addr=RESET_PC and fetch_count=0 immediately. The normal sequence restarts after release.
